reg_cmd_master: RTL and testbench

Command initiator for the control-register port: accepts register read/write requests from an upstream configuration source over a valid/ready handshake and buffers them in a small in-order FIFO. It drives the 2-bit register command bus (`cmd`/`addr`/`data`) into the control-register block one command per cycle. Read data is captured from the register block and returned on a valid/ready response channel.

---
 rtl/reg_cmd_master.sv | 139 +++++++++++++
 tb/tb_reg_cmd_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_master.sv
// Register command initiator: queues read/write requests in an in-order FIFO,
// drives one command per cycle on the register bus, and returns read data on a response channel.
module reg_cmd_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic                               req_write_i,
  input  logic [ADDR_W-1:0]                  req_addr_i,
  input  logic [DATA_W-1:0]                  req_data_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [DATA_W-1:0]                  rsp_data_o,
  output logic [1:0]                         cmd_o,
  output logic [ADDR_W-1:0]                  cmd_addr_o,
  output logic [DATA_W-1:0]                  cmd_data_o,
  input  logic [DATA_W-1:0]                  cmd_data_i,
  output logic                               busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_RSP
  } state_t;

  state_t state, state_nxt;

  logic [FIFO_DEPTH-1:0] fifo_write_q;
  logic [ADDR_W-1:0]     fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              capture;
  logic [1:0]        cmd_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;

  assign req_ready_o = (count != FULL_CNT);
  assign fifo_empty  = (count == '0);
  assign push        = req_valid_i && req_ready_o;
  assign fifo_cnt_o  = count;
  assign busy_o      = !fifo_empty || (state != S_IDLE);
  assign rsp_valid_o = (state == S_RSP);

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_write_q[wr_ptr] <= req_write_i;
      fifo_addr_q[wr_ptr]  <= req_addr_i;
      fifo_data_q[wr_ptr]  <= req_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A WRITE may chain straight into the next pop; a READ blocks until its response is taken.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    cmd_nxt   = CMD_IDLE;
    addr_nxt  = '0;
    data_nxt  = '0;
    case (state)
      S_IDLE, S_WR: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = fifo_write_q[rd_ptr] ? S_WR : S_RD;
          cmd_nxt   = fifo_write_q[rd_ptr] ? CMD_WRITE : CMD_READ;
          addr_nxt  = fifo_addr_q[rd_ptr];
          data_nxt  = fifo_write_q[rd_ptr] ? fifo_data_q[rd_ptr] : '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RD:  state_nxt = S_CAP;
      S_CAP: begin
        capture   = 1'b1;
        state_nxt = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= S_IDLE;
      cmd_o      <= CMD_IDLE;
      cmd_addr_o <= '0;
      cmd_data_o <= '0;
      rsp_data_o <= '0;
    end else begin
      state      <= state_nxt;
      cmd_o      <= cmd_nxt;
      cmd_addr_o <= addr_nxt;
      cmd_data_o <= data_nxt;
      if (capture) rsp_data_o <= cmd_data_i;
    end
  end

endmodule

// File: tb/tb_reg_cmd_master.sv
// Bench for reg_cmd_master: directed scenarios plus random traffic, checked every cycle
// against a timing-rule model of accepted requests and a behavioural register block.
module tb_reg_cmd_master;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic              req_write_i = 1'b0;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic [DATA_W-1:0] req_data_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b1;
  logic [DATA_W-1:0] rsp_data_o;
  logic [1:0]        cmd_o;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic [DATA_W-1:0] cmd_data_o;
  logic [DATA_W-1:0] cmd_data_i;
  logic              busy_o;
  logic [2:0]        fifo_cnt_o;

  reg_cmd_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write_i),
    .req_addr_i(req_addr_i),
    .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o),
    .cmd_o(cmd_o),
    .cmd_addr_o(cmd_addr_o),
    .cmd_data_o(cmd_data_o),
    .cmd_data_i(cmd_data_i),
    .busy_o(busy_o),
    .fifo_cnt_o(fifo_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        w;
    logic [7:0]  addr;
    logic [31:0] data;
    int          acc;
  } req_t;

  req_t        exp_q[$];
  req_t        head;
  logic [31:0] regs [256];
  logic [31:0] exp_rsp = '0;
  logic        nxt_rd_valid = 1'b0;
  logic [31:0] nxt_rd_data = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rd_cyc = 0;
  int          ready_cyc = 0;
  bit          started = 1'b0;
  bit          rd_out = 1'b0;
  bit          after_rst = 1'b1;
  bit          rand_rsp = 1'b0;
  bit          exp_issue;
  bit          exp_valid;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_rsp) rsp_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [31:0] d);
    bit accepted;
    accepted    = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_data_i  = d;
    for (int g = 0; g < 200 && !accepted; g++) begin
      @(negedge clk_i);
      accepted = req_ready_o;
      tick();
    end
    req_valid_i = 1'b0;
    req_write_i = 1'($urandom_range(0, 1));
    req_addr_i  = 8'($urandom);
    req_data_i  = $urandom;
    if (!accepted) checkOutput("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitRsp();
    bit found;
    found = 1'b0;
    for (int g = 0; g < 60 && !found; g++) begin
      @(negedge clk_i);
      if (rsp_valid_o === 1'b1) found = 1'b1;
      else tick();
    end
    if (!found) checkOutput("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int g = 0; g < 400 && !done; g++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) done = 1'b1;
      tick();
    end
    if (!done) checkOutput("idle_timeout", 64'd0, 64'd1);
  endtask

  // Behavioural register block: returns read data only in the cycle after a READ.
  always @(posedge clk_i) begin
    #1;
    cmd_data_i = nxt_rd_valid ? nxt_rd_data : $urandom;
  end

  // Reference model: a request accepted in cycle a issues no earlier than a+2, strictly in order,
  // back-to-back when possible, and never while a read is outstanding or within two cycles of its handshake.
  always @(negedge clk_i) begin
    if (started) begin
      cyc++;
      exp_issue = !rd_out && (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2) && (cyc >= ready_cyc);
      if (exp_issue) begin
        head = exp_q.pop_front();
        checkOutput("cmd", 64'(cmd_o), head.w ? 64'd2 : 64'd1);
        checkOutput("cmd_addr", 64'(cmd_addr_o), 64'(head.addr));
        checkOutput("cmd_data", 64'(cmd_data_o), head.w ? 64'(head.data) : 64'd0);
        if (head.w) begin
          regs[head.addr] = head.data;
        end else begin
          rd_out  = 1'b1;
          rd_cyc  = cyc;
          exp_rsp = regs[head.addr];
        end
      end else begin
        checkOutput("cmd_idle", 64'(cmd_o), 64'd0);
        checkOutput("cmd_addr_idle", 64'(cmd_addr_o), 64'd0);
        checkOutput("cmd_data_idle", 64'(cmd_data_o), 64'd0);
      end
      nxt_rd_valid = (cmd_o === 2'b01);
      nxt_rd_data  = regs[cmd_addr_o];
      exp_valid    = rd_out && (cyc >= rd_cyc + 2);
      checkOutput("rsp_valid", 64'(rsp_valid_o), 64'(exp_valid));
      if (exp_valid) checkOutput("rsp_data", 64'(rsp_data_o), 64'(exp_rsp));
      if (after_rst) checkOutput("rsp_data_rst", 64'(rsp_data_o), 64'd0);
      checkOutput("fifo_cnt", 64'(fifo_cnt_o), 64'(exp_q.size()));
      checkOutput("req_ready", 64'(req_ready_o), 64'(exp_q.size() != FIFO_DEPTH));
      checkOutput("busy", 64'(busy_o), 64'((exp_q.size() != 0) || exp_issue || rd_out));
      after_rst = !rstn_i;
      if (!rstn_i) begin
        exp_q.delete();
        rd_out    = 1'b0;
        ready_cyc = 0;
      end else begin
        if (exp_valid && rsp_ready_i) begin
          rd_out    = 1'b0;
          ready_cyc = cyc + 2;
        end
        if (req_valid_i && exp_q.size() < FIFO_DEPTH)
          exp_q.push_back('{w: req_write_i, addr: req_addr_i, data: req_data_i, acc: cyc});
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) regs[i] = $urandom;
    regs[8'h10] = 32'hDEADBEEF;

    repeat (2) @(posedge clk_i);
    #1;
    started = 1'b1;
    tick();
    rstn_i = 1'b1;

    // Three back-to-back writes
    applyStimulus(1'b1, 8'h00, 32'h1);
    applyStimulus(1'b1, 8'h04, 32'h2);
    applyStimulus(1'b1, 8'h08, 32'h3);
    waitIdle();

    // Single read of a preloaded register
    applyStimulus(1'b0, 8'h10, $urandom);
    waitRsp();
    checkOutput("rd_deadbeef", 64'(rsp_data_o), 64'h0000_0000_DEAD_BEEF);
    tick();
    waitIdle();

    // Read held un-acknowledged while the FIFO fills
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 8'h30, $urandom);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h40 + 4 * i), $urandom);
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 8'h40;
    req_data_i  = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checkOutput("full_ready", 64'(req_ready_o), 64'd0);
      checkOutput("full_cnt", 64'(fifo_cnt_o), 64'd4);
      tick();
    end
    rsp_ready_i = 1'b1;
    applyStimulus(1'b0, 8'h40, 32'h0);
    waitIdle();

    // Write, read-back, write
    applyStimulus(1'b1, 8'h20, 32'hA5);
    applyStimulus(1'b0, 8'h20, $urandom);
    applyStimulus(1'b1, 8'h24, 32'h5A);
    waitRsp();
    checkOutput("interleave_rsp", 64'(rsp_data_o), 64'hA5);
    tick();
    waitIdle();

    // Reset pulse while the read is in its capture cycle
    applyStimulus(1'b0, 8'h18, $urandom);
    begin
      bit seen;
      seen = 1'b0;
      for (int g = 0; g < 20 && !seen; g++) begin
        @(negedge clk_i);
        seen = (cmd_o === 2'b01);
        tick();
      end
      if (!seen) checkOutput("read_timeout", 64'd0, 64'd1);
    end
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    @(negedge clk_i);
    checkOutput("cap_rst_cnt", 64'(fifo_cnt_o), 64'd0);
    checkOutput("cap_rst_ready", 64'(req_ready_o), 64'd1);
    checkOutput("cap_rst_valid", 64'(rsp_valid_o), 64'd0);
    tick();

    // Reset pulse while a response is pending and the FIFO holds requests
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 8'h1C, $urandom);
    applyStimulus(1'b1, 8'h50, $urandom);
    applyStimulus(1'b1, 8'h54, $urandom);
    waitRsp();
    tick();
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rsp_rst_cnt", 64'(fifo_cnt_o), 64'd0);
    checkOutput("rsp_rst_ready", 64'(req_ready_o), 64'd1);
    checkOutput("rsp_rst_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("rsp_rst_data", 64'(rsp_data_o), 64'd0);
    tick();
    rsp_ready_i = 1'b1;
    waitIdle();

    // Push and pop together once two writes are queued behind a stalled read
    rsp_ready_i = 1'b0;
    applyStimulus(1'b0, 8'h30, $urandom);
    applyStimulus(1'b1, 8'h60, $urandom);
    applyStimulus(1'b1, 8'h64, $urandom);
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h68 + 4 * i), $urandom);
    waitIdle();

    // Random traffic with random response back-pressure and occasional resets
    rand_rsp = 1'b1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 59) == 0) begin
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
      end
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15) * 4), $urandom);
    end
    rand_rsp    = 1'b0;
    rsp_ready_i = 1'b1;
    waitIdle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
